// File: rtl/ram_stream_reader_if.sv
// ram_stream_reader_if: RAM read port plus valid/ready byte stream of the reader.
interface ram_stream_reader_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 8
);
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_en;
  logic [DATA_W-1:0] ram_q;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;
  logic              out_last;
  modport master (
    output rd_addr, rd_en, out_data, out_valid, out_last,
    input  ram_q, out_ready
  );
  modport slave (
    input  rd_addr, rd_en, out_data, out_valid, out_last,
    output ram_q, out_ready
  );
endinterface

// File: rtl/ram_stream_reader.sv
// ram_stream_reader: reads a wrapping run of RAM words into a credit-controlled FIFO
// and presents them as a valid/ready stream with last flag and a done pulse.
module ram_stream_reader #(
  parameter int ADDR_W     = 5,
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [ADDR_W-1:0]   base_addr,
  input  logic [ADDR_W:0]     length,
  output logic                busy,
  output logic                done,
  ram_stream_reader_if.master bus
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, FIN} state_e;
  state_e            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d, rd_addr_q, rd_addr_d;
  logic [ADDR_W:0]   len_q, len_d, issued_q, issued_d;
  logic              infl_q, infl_d, infl_last_q, infl_last_d;
  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic [DATA_W-1:0] mem_d [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] last_q, last_d;
  logic [PW-1:0]     wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0]     count_q, count_d;
  logic [CW:0]       used;
  logic              rd_en, can_issue, push, pop, drain_done;

  function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // The word read last cycle is on ram_q now and lands in the FIFO at this edge.
  assign push       = infl_q;
  assign pop        = bus.out_valid & bus.out_ready;
  assign used       = {1'b0, count_q} + {{CW{1'b0}}, infl_q};
  assign can_issue  = used < (CW + 1)'(FIFO_DEPTH);
  assign drain_done = !infl_q && (count_q == '0 || (count_q == CW'(1) && pop));

  assign bus.out_valid = count_q != '0;
  assign bus.out_data  = mem_q[rd_q];
  assign bus.out_last  = last_q[rd_q];
  assign bus.rd_addr   = rd_addr_d;
  assign bus.rd_en     = rd_en;
  assign busy          = state_q == ISSUE || state_q == DRAIN;
  assign done          = state_q == FIN;

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    len_d       = len_q;
    issued_d    = issued_q;
    rd_addr_d   = rd_addr_q;
    rd_en       = 1'b0;
    infl_d      = 1'b0;
    infl_last_d = 1'b0;
    case (state_q)
      IDLE: if (start) begin
        state_d  = (length != '0) ? ISSUE : FIN;
        len_d    = length;
        ptr_d    = base_addr;
        issued_d = '0;
      end
      ISSUE: if (can_issue) begin
        rd_en       = 1'b1;
        rd_addr_d   = ptr_q;
        ptr_d       = ptr_q + 1'b1;
        issued_d    = issued_q + 1'b1;
        infl_d      = 1'b1;
        infl_last_d = issued_d == len_q;
        state_d     = (issued_d == len_q) ? DRAIN : ISSUE;
      end
      DRAIN: state_d = drain_done ? FIN : DRAIN;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    mem_d  = mem_q;
    last_d = last_q;
    if (push) begin
      mem_d[wr_q]  = bus.ram_q;
      last_d[wr_q] = infl_last_q;
    end
    wr_d    = push ? wrap_inc(wr_q) : wr_q;
    rd_d    = pop ? wrap_inc(rd_q) : rd_q;
    count_d = count_q + CW'(push) - CW'(pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      rd_addr_q   <= '0;
      len_q       <= '0;
      issued_q    <= '0;
      infl_q      <= 1'b0;
      infl_last_q <= 1'b0;
      mem_q       <= '{default: '0};
      last_q      <= '0;
      wr_q        <= '0;
      rd_q        <= '0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      rd_addr_q   <= rd_addr_d;
      len_q       <= len_d;
      issued_q    <= issued_d;
      infl_q      <= infl_d;
      infl_last_q <= infl_last_d;
      mem_q       <= mem_d;
      last_q      <= last_d;
      wr_q        <= wr_d;
      rd_q        <= rd_d;
      count_q     <= count_d;
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && count_q == CW'(FIFO_DEPTH)));
endmodule

// File: tb/tb_ram_stream_reader.sv
// tb_ram_stream_reader: randomized and directed stimulus against a queue-based stream model
// plus a registered-read RAM model holding the memory image.
module tb_ram_stream_reader;
  localparam int FD = 4;
  localparam int MD = 32;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [4:0] base_addr;
  logic [5:0] length;
  logic       busy, done;
  logic [7:0] mem [MD];
  int passed = 0, total = 0;
  int cyc = 0;
  int rdy_mode = 0, rdy_k = 0;
  bit rdy_fix = 1'b1;

  ram_stream_reader_if #(.ADDR_W(5), .DATA_W(8)) bus ();

  ram_stream_reader #(.ADDR_W(5), .DATA_W(8), .FIFO_DEPTH(FD)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
    .length(length), .busy(busy), .done(done), .bus(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) bus.ram_q <= mem[bus.rd_addr];

  task automatic check(input string name, input int act, input int want);
    total++;
    if (act == want) passed++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, want, cyc);
  endtask

  // Model of the command: the words it must deliver, and bookkeeping for timing.
  bit m_active, m_done_next, prev_stall, prev_last, act0, dexp;
  int m_base, m_len, m_iss, m_xfer, prev_data, prev_addr;
  int exp_data[$];
  bit exp_last[$];
  int log_data[$], log_addr[$], xfer_cyc[$];
  bit log_last[$];
  int done_cnt, valid_cnt, accept_cyc, first_valid_cyc, done_cyc;

  always @(negedge clk) begin
    if (!rst_n) begin
      m_active = 0; m_done_next = 0; prev_stall = 0; prev_addr = 0;
      m_iss = 0; m_xfer = 0;
      exp_data.delete(); exp_last.delete();
    end else begin
      act0 = m_active;
      dexp = m_active && m_done_next;
      check("done", int'(done), int'(dexp));
      check("busy", int'(busy), int'(m_active && !dexp));
      if (done) begin done_cnt++; done_cyc = cyc; end
      if (bus.rd_en) begin
        check("rd_en_in_command", int'(m_active && m_iss < m_len), 1);
        check("rd_addr", int'(bus.rd_addr), (m_base + m_iss) % MD);
        log_addr.push_back(int'(bus.rd_addr));
        m_iss++;
      end else check("rd_addr_hold", int'(bus.rd_addr), prev_addr);
      prev_addr = int'(bus.rd_addr);
      check("credit_bound", int'(m_iss - m_xfer <= FD), 1);
      if (prev_stall) begin
        check("valid_held", int'(bus.out_valid), 1);
        check("data_stable", int'(bus.out_data), prev_data);
        check("last_stable", int'(bus.out_last), int'(prev_last));
      end
      if (bus.out_valid) begin
        valid_cnt++;
        if (first_valid_cyc < 0) first_valid_cyc = cyc;
        check("valid_has_word", int'(exp_data.size() != 0), 1);
        if (exp_data.size() != 0) begin
          check("out_data", int'(bus.out_data), exp_data[0]);
          check("out_last", int'(bus.out_last), int'(exp_last[0]));
        end
        if (bus.out_ready && exp_data.size() != 0) begin
          log_data.push_back(int'(bus.out_data));
          log_last.push_back(bus.out_last);
          xfer_cyc.push_back(cyc);
          void'(exp_data.pop_front());
          void'(exp_last.pop_front());
          m_xfer++;
          if (exp_data.size() == 0) m_done_next = 1;
        end
      end
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_data  = int'(bus.out_data);
      prev_last  = bus.out_last;
      if (dexp) begin m_active = 0; m_done_next = 0; end
      if (!act0 && start) begin
        m_active = 1; m_base = int'(base_addr); m_len = int'(length);
        m_iss = 0; m_xfer = 0; m_done_next = (m_len == 0);
        accept_cyc = cyc; first_valid_cyc = -1;
        for (int i = 0; i < m_len; i++) begin
          exp_data.push_back(int'(mem[(m_base + i) % MD]));
          exp_last.push_back(i == m_len - 1);
        end
      end
    end
  end

  initial forever begin
    @(posedge clk); #1;
    if (rdy_mode == 0) bus.out_ready = rdy_fix;
    else if (rdy_mode == 1) begin bus.out_ready = (rdy_k % 3 == 0); rdy_k++; end
    else bus.out_ready = ($urandom_range(0, 9) < 6);
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic cmd(input int b, input int l);
    start = 1'b1; base_addr = 5'(b); length = 6'(l);
    tick(1);
    start = 1'b0;
  endtask

  task automatic wait_idle(input int limit);
    int k = 0;
    while (m_active && k < limit) begin tick(1); k++; end
    check("cmd_finished", int'(m_active), 0);
  endtask

  task automatic clear_logs();
    log_data.delete(); log_last.delete(); log_addr.delete(); xfer_cyc.delete();
    done_cnt = 0; valid_cnt = 0;
  endtask

  task automatic check_seq(input string name, input int first, input int n);
    check({name, "_count"}, log_data.size(), n);
    for (int i = 0; i < n && i < log_data.size(); i++) begin
      check({name, "_data"}, log_data[i], (first + i) % MD);
      check({name, "_last"}, int'(log_last[i]), int'(i == n - 1));
    end
  endtask

  initial begin
    int e2[4];
    int b, l;
    rst_n = 1'b0; start = 1'b0; base_addr = '0; length = '0; bus.out_ready = 1'b0;
    for (int i = 0; i < MD; i++) mem[i] = 8'(i);
    clear_logs();
    tick(3);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_valid", int'(bus.out_valid), 0);
    check("rst_rd_en", int'(bus.rd_en), 0);
    rst_n = 1'b1;
    tick(2);
    // base 0, length 5, always ready
    rdy_mode = 0; rdy_fix = 1; tick(1);
    clear_logs(); cmd(0, 5); wait_idle(100);
    check_seq("t1", 0, 5);
    check("t1_first_valid_lat", first_valid_cyc - accept_cyc, 3);
    if (xfer_cyc.size() == 5) begin
      check("t1_throughput", xfer_cyc[4] - xfer_cyc[0], 4);
      check("t1_done_after_last", done_cyc - xfer_cyc[4], 1);
    end
    check("t1_done_cnt", done_cnt, 1);
    check("t1_busy_after", int'(busy), 0);
    // wrap-around
    clear_logs(); cmd(30, 4); wait_idle(100);
    e2 = '{30, 31, 0, 1};
    check("t2_reads", log_addr.size(), 4);
    for (int i = 0; i < 4 && i < log_addr.size(); i++) check("t2_rd_addr", log_addr[i], e2[i]);
    check_seq("t2", 30, 4);
    // full memory with 1,0,0 backpressure
    rdy_mode = 1; rdy_k = 0;
    clear_logs(); cmd(0, 32); wait_idle(300);
    check_seq("t3", 0, 32);
    check("t3_reads", log_addr.size(), 32);
    // no ready at all: reads stop at FIFO_DEPTH
    rdy_mode = 0; rdy_fix = 0; tick(1);
    clear_logs(); cmd(0, 10); tick(20);
    check("t4_reads_stalled", log_addr.size(), FD);
    check("t4_valid", int'(bus.out_valid), 1);
    check("t4_head", int'(bus.out_data), 0);
    rdy_fix = 1; wait_idle(200);
    check_seq("t4", 0, 10);
    // zero length, then start while busy
    clear_logs(); cmd(7, 0); wait_idle(20);
    check("t5_no_reads", log_addr.size(), 0);
    check("t5_no_valid", valid_cnt, 0);
    check("t5_done_cnt", done_cnt, 1);
    clear_logs(); cmd(0, 8); tick(2); cmd(20, 3); tick(3); cmd(5, 5); wait_idle(100);
    check_seq("t5", 0, 8);
    check("t5_done_once", done_cnt, 1);
    // asynchronous reset mid-run
    clear_logs(); cmd(0, 16); tick(6);
    #2 rst_n = 1'b0;
    #1;
    check("t6_busy", int'(busy), 0);
    check("t6_done", int'(done), 0);
    check("t6_valid", int'(bus.out_valid), 0);
    check("t6_data", int'(bus.out_data), 0);
    check("t6_last", int'(bus.out_last), 0);
    check("t6_rd_en", int'(bus.rd_en), 0);
    check("t6_rd_addr", int'(bus.rd_addr), 0);
    tick(2); rst_n = 1'b1; tick(1);
    clear_logs(); cmd(3, 2); wait_idle(50);
    check_seq("t6", 3, 2);
    check("t6_done_cnt", done_cnt, 1);
    // randomized commands, memory contents and backpressure
    rdy_mode = 2;
    for (int n = 0; n < 20; n++) begin
      for (int i = 0; i < MD; i++) mem[i] = 8'($urandom_range(0, 255));
      b = $urandom_range(0, MD - 1);
      l = ($urandom_range(0, 4) == 0) ? (($urandom_range(0, 1) == 1) ? 0 : MD) : $urandom_range(1, MD);
      clear_logs(); cmd(b, l);
      tick($urandom_range(0, 4));
      if (m_active) cmd($urandom_range(0, MD - 1), $urandom_range(0, MD));
      wait_idle(400);
      check("rnd_count", log_data.size(), l);
      check("rnd_done_cnt", done_cnt, 1);
      tick($urandom_range(0, 3));
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/ram_stream_reader.md
Name: ram_stream_reader

Overview:
- Read-side controller for the 32x8 single-clock initialised RAM, which has a registered read port (q updates on posedge clk from read_address).
- On a start command, reads LENGTH consecutive words from a base address, wrapping modulo the memory depth.
- Presents the words as a valid/ready byte stream, with a last flag and a completion pulse.
- Absorbs the RAM's 1-cycle read latency and downstream backpressure through an internal credit-controlled FIFO.

Parameters:
- ADDR_W, 5, RAM address width; memory depth is 2**ADDR_W.
- DATA_W, 8, RAM word and stream data width.
- FIFO_DEPTH, 4, output buffer entries; legal values are 3..8.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset.
- start  in  1  command strobe; sampled only in IDLE.
- base_addr  in  ADDR_W  first word address; captured with start.
- length  in  ADDR_W+1  word count, 0..2**ADDR_W; captured with start.
- rd_addr  out  ADDR_W  to the RAM read_address.
- rd_en  out  1  high in the cycle a read is issued on rd_addr.
- ram_q  in  DATA_W  from the RAM q; holds mem[rd_addr sampled at the previous edge].
- out_data  out  DATA_W  stream data; equals the FIFO head.
- out_valid  out  1  FIFO not empty.
- out_ready  in  1  downstream accept.
- out_last  out  1  head word is the final word of the command.
- busy  out  1  command in progress.
- done  out  1  one-cycle completion pulse.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
- Reset values: all outputs 0, state IDLE, FIFO empty, counters 0.
- Reset asserted mid-command aborts immediately. Words in flight or buffered are discarded. No done pulse is produced.
- States: IDLE, ISSUE, DRAIN, FIN.
- IDLE:
  - start=1 with length>0: capture base_addr and length, set issue pointer = base_addr, issued = 0, go to ISSUE, busy=1 from the next cycle.
  - start=1 with length==0: go to FIN; no beats are produced.
  - start=0: stay in IDLE.
- ISSUE:
  - Issue condition: occupancy + in_flight < FIFO_DEPTH, using registered values.
  - When the condition holds: rd_en=1, rd_addr = issue pointer, pointer = (pointer+1) mod 2**ADDR_W, issued += 1.
  - When issued reaches length, go to DRAIN.
  - rd_addr holds its last value whenever rd_en=0.
- Read return:
  - A read issued in cycle n is pushed into the FIFO at the end of cycle n+1, with data = ram_q.
  - in_flight is 0 or 1.
  - The last-word tag travels with the word: it is set when the word's index == length-1.
- DRAIN: when the FIFO is empty and in_flight==0 and the final handshake has occurred, go to FIN.
- FIN: done=1 for exactly one cycle. busy deasserts at the same edge that done asserts. Next state is IDLE.
- start while busy (ISSUE, DRAIN, FIN) is ignored; base_addr and length changes mid-command are ignored.
- Stream rules:
  - out_data, out_valid and out_last are driven from FIFO registers only; no combinational path from out_ready.
  - A transfer occurs when out_valid & out_ready.
  - Once out_valid is high, out_data and out_last stay stable until the transfer.
- Simultaneous push and pop in one cycle: occupancy is unchanged and ordering is preserved.
- Throughput: with out_ready held high, one word per cycle after the first.
- First out_valid: 2 cycles after the first rd_en cycle, i.e. 3 cycles after the start cycle.
- Credit check prevents overflow: a push to a full FIFO is impossible by construction. A verification assertion checks this.
- Wrap-around: base_addr=30, length=4 reads addresses 30, 31, 0, 1.
- length = 2**ADDR_W (32) reads the entire memory exactly once.

Test Plan:
- RAM holds mem[i]=i. start with base=0, length=5, out_ready=1 -> out_data 0,1,2,3,4 on consecutive cycles; out_last only on 4; done pulses one cycle after the last transfer; busy low afterwards.
- base=30, length=4 -> rd_addr sequence 30,31,0,1; data 30,31,0,1; out_last on the word 1.
- length=32, out_ready toggling 1,0,0,1,... -> all 32 words in order with no loss or duplication; FIFO occupancy never exceeds FIFO_DEPTH; out_data is stable while stalled.
- out_ready=0 throughout, length=10 -> exactly FIFO_DEPTH reads issued, then rd_en stays 0. Raising out_ready resumes the stream with words 0..9 in order.
- start with length=0 -> no rd_en and no out_valid; done pulses once. A second start while busy during a length=8 run is ignored: exactly 8 words and one done.
- rst_n pulsed low mid-run of length=16 -> all outputs 0 at once. A fresh start with base=3, length=2 then yields 3,4 and one done.
